// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receiver.
package deser_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } deser_state_t;

    // Bit-counter width for a word of the given size.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// A write that finds the entry full and not draining is dropped and flagged.
module deser_out_buf
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full_drop
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             drain;
    logic             accept;

    assign drain     = valid_q && rd_ready;
    assign accept    = wr_en && (!valid_q || rd_ready);
    assign full_drop = wr_en && valid_q && !rd_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (accept) begin
            data_d  = wr_data;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the data register is reset as well because dout must read 0 after reset,
            // even though its value is otherwise only meaningful while valid is set.
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/deserializer_4bit.sv
// LSB-first serial receiver: aligns on sync, assembles WIDTH-bit words and
// hands them to a one-entry output buffer with overrun and framing reporting.
module deserializer_4bit
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sync,
    input  logic             dout_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun,
    output logic             frame_err
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             wr_en;
    logic             full_drop;

    assign shifted = {sin, shreg_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sin_en && sync) begin
                    shreg_d = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sin_en) begin
                    shreg_d = shifted;
                    // A sync mid-word restarts the word at this bit; stale bits age out of shreg.
                    if (sync && cnt_q != '0) begin
                        frame_err_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        wr_en = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        overrun_d = overrun_q;
        if (full_drop) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated only with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    deser_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (shifted),
        .rd_ready  (dout_ready),
        .data      (dout),
        .valid     (dout_valid),
        .full_drop (full_drop)
    );

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_deserializer_4bit.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// every cycle against a bit-queue reference model of the receiver.
module tb_deserializer_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_en;
    logic         sync;
    logic         dout_ready;
    logic         err_clr;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         overrun;
    logic         frame_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit           m_aligned;
    bit           m_bits[$];
    logic [W-1:0] m_dout;
    bit           m_valid;
    bit           m_ovr;
    bit           m_ferr;

    always #5 clk = ~clk;

    deserializer_4bit #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .sync       (sync),
        .dout_ready (dout_ready),
        .err_clr    (err_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit           completed;
        bit           drain;
        bit           ovr_set;
        logic [W-1:0] word;
        completed = 1'b0;
        ovr_set   = 1'b0;
        word      = '0;
        if (!rst) begin
            m_aligned = 1'b0;
            m_bits.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            return;
        end
        m_ferr = 1'b0;
        drain  = m_valid && dout_ready;
        if (sin_en) begin
            if (sync) begin
                if (m_aligned && m_bits.size() != 0) m_ferr = 1'b1;
                m_bits.delete();
                m_aligned = 1'b1;
                m_bits.push_back(sin);
            end else if (m_aligned) begin
                m_bits.push_back(sin);
            end
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) word[i] = m_bits[i];
                m_bits.delete();
                completed = 1'b1;
            end
        end
        if (completed) begin
            if (!m_valid || drain) begin
                m_dout  = word;
                m_valid = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (drain) begin
            m_valid = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (err_clr) m_ovr = 1'b0;
    endtask

    // Apply inputs, clock once, then compare every output against the model.
    task automatic cyc(input logic r, input logic s, input logic en, input logic sy,
                       input logic rdy, input logic ec);
        rst        = r;
        sin        = s;
        sin_en     = en;
        sync       = sy;
        dout_ready = rdy;
        err_clr    = ec;
        @(posedge clk);
        model_edge();
        #1;
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit with_sync, input logic rdy);
        for (int i = 0; i < W; i++) cyc(1'b1, w[i], 1'b1, with_sync && i == 0, rdy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] gw;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // Single word 1,0,1,1 -> 0xD
        send_word(4'hD, 1'b1, 1'b1);
        check("word_d", 32'(dout), 32'hD);
        check("word_d_valid", 32'(dout_valid), 32'h1);
        idle(1'b1);
        check("word_d_drained", 32'(dout_valid), 32'h0);

        // Continuous 8 bits after one sync -> 0xA then 0x5
        send_word(4'hA, 1'b1, 1'b1);
        check("word_a", 32'(dout), 32'hA);
        send_word(4'h5, 1'b0, 1'b1);
        check("word_5", 32'(dout), 32'h5);
        check("word_5_valid", 32'(dout_valid), 32'h1);
        idle(1'b1);

        // Overrun: 0x3 held, 0xC dropped
        send_word(4'h3, 1'b1, 1'b0);
        send_word(4'hC, 1'b0, 1'b0);
        check("ovr_hold", 32'(dout), 32'h3);
        check("ovr_flag", 32'(overrun), 32'h1);
        idle(1'b1);
        check("ovr_drained", 32'(dout_valid), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Framing error: 2 bits, then sync + 1,0,0,1 -> 0x9
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("ferr_pulse", 32'(frame_err), 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ferr_one_cycle", 32'(frame_err), 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ferr_word_9", 32'(dout), 32'h9);
        idle(1'b1);

        // Gapped bits must assemble the same word as contiguous ones
        gw = W'($urandom);
        for (int i = 0; i < W; i++) begin
            cyc(1'b1, gw[i], 1'b1, i == 0, 1'b1, 1'b0);
            if (i != W - 1) begin
                int gaps = $urandom_range(1, 3);
                for (int g = 0; g < gaps; g++)
                    cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom), 1'b1, 1'b0);
            end
        end
        check("gapped_word", 32'(dout), 32'(gw));
        check("gapped_valid", 32'(dout_valid), 32'h1);
        idle(1'b1);

        // Reset mid-word, then bits without sync produce nothing
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) begin
            cyc(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
            check("rst_mid_no_valid", 32'(dout_valid), 32'h0);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) != 0,
                1'($urandom),
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
